// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared types, constants and helpers for the reset sequencer
package reset_sequencer_pkg;

  localparam int COUNT_WIDTH = 8;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    COUNT = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Width of a counter that must hold values 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == {COUNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_debounce.sv
// rtl/reset_sequencer_sync_debounce.sv - input synchronizer chain followed by a stable-count debouncer
module sync_debounce
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 650_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int             DW      = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   din_s;
  logic                   dout_q, dout_d;
  logic [DW-1:0]          db_cnt_q, db_cnt_d;

  assign din_s = sync_q[SYNC_STAGES-1];
  assign dout  = dout_q;

  // Counter only advances while the synchronized input disagrees with the accepted value.
  always_comb begin
    dout_d   = dout_q;
    db_cnt_d = '0;
    if (din_s != dout_q) begin
      if (db_cnt_q == DB_LAST) begin
        dout_d = din_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      dout_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
      dout_q   <= dout_d;
      db_cnt_q <= db_cnt_d;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - turns button and PLL-locked inputs into a clean, held, active-low SoC reset
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int CLOCK_FREQ      = 65_000_000,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 650_000,
  parameter int HOLD_CYCLES     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   button_n_i,
  input  logic                   locked_i,
  output logic                   soc_rst_n_o,
  output logic                   reset_active_o,
  output logic [COUNT_WIDTH-1:0] reset_count_o
);

  localparam int            HW        = cnt_width(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  // Empty marker block: a non-positive clock frequency is a configuration error.
  if (CLOCK_FREQ < 1) begin : g_invalid_clock_freq
  end

  logic [SYNC_STAGES-1:0]  lock_sync_q;
  logic                    lock_s;
  logic                    btn_db;
  logic                    release_ok;
  state_t                  state_q, state_d;
  logic [HW-1:0]           hold_cnt_q, hold_cnt_d;
  logic [COUNT_WIDTH-1:0]  rst_cnt_q, rst_cnt_d;
  logic                    soc_rst_n_q;
  logic                    reset_active_q;

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_sync_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (button_n_i),
    .dout (btn_db)
  );

  assign lock_s     = lock_sync_q[SYNC_STAGES-1];
  assign release_ok = lock_s & btn_db;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    rst_cnt_d  = rst_cnt_q;
    case (state_q)
      HOLD: begin
        if (release_ok) state_d = COUNT;
      end
      COUNT: begin
        // Losing lock or button wins over hold completion.
        if (!release_ok) begin
          state_d = HOLD;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!release_ok) begin
          state_d   = HOLD;
          rst_cnt_d = sat_inc(rst_cnt_q);
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync_q    <= '0;
      state_q        <= HOLD;
      hold_cnt_q     <= '0;
      rst_cnt_q      <= '0;
      soc_rst_n_q    <= 1'b0;
      reset_active_q <= 1'b1;
    end else begin
      lock_sync_q    <= {lock_sync_q[SYNC_STAGES-2:0], locked_i};
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      rst_cnt_q      <= rst_cnt_d;
      soc_rst_n_q    <= (state_d == RUN);
      reset_active_q <= (state_d != RUN);
    end
  end

  assign soc_rst_n_o    = soc_rst_n_q;
  assign reset_active_o = reset_active_q;
  assign reset_count_o  = rst_cnt_q;

endmodule
